// File: rtl/gpu_mem_controller_pkg.sv
// Shared types and helpers for the core->memory request controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_mem_controller_pkg;

    typedef enum logic [1:0] {
        MC_IDLE    = 2'd0,
        MC_ISSUE   = 2'd1,
        MC_WAIT    = 2'd2,
        MC_RESPOND = 2'd3
    } mc_state_e;

    // Index width for a pool of n requesters; never zero so single-core builds stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpu_mem_controller_if.sv
// Bundles the per-core request/response lanes and the data-memory port.
// Latency: n/a (wires only).
// Backpressure: cores hold a request until their one-hot ready pulse.
interface gpu_mem_controller_if #(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [NUM_CORES-1:0]            core_req_valid;
    logic [NUM_CORES-1:0]            core_req_we;
    logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_req_wdata;
    logic [NUM_CORES-1:0]            core_req_ready;
    logic [NUM_CORES-1:0]            core_resp_valid;
    logic [NUM_CORES*DATA_WIDTH-1:0] core_resp_rdata;
    logic                            mem_en;
    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    // Cores plus the memory model: drive requests and read data.
    modport master (
        output core_req_valid, core_req_we, core_req_addr, core_req_wdata, mem_rdata,
        input  core_req_ready, core_resp_valid, core_resp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // The controller: accepts requests, drives memory and responses.
    modport slave (
        input  core_req_valid, core_req_we, core_req_addr, core_req_wdata, mem_rdata,
        output core_req_ready, core_resp_valid, core_resp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/gpu_mem_controller_rr_arbiter.sv
// Round-robin pick of the first requesting core at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module gpu_mem_controller_rr_arbiter
    import gpu_mem_controller_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Scan from ptr upward; the first hit wins, later hits are ignored.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        cand         = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any                = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_mem_controller.sv
// Arbitrates core load/store requests onto one sync-read memory, one request at a time.
// Latency: ready at T, mem strobe at T+1, response pulse at T+3, next grant no earlier than T+4.
// Backpressure: ready only in IDLE; other cores hold their request until granted.
module gpu_mem_controller
    import gpu_mem_controller_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_SIZE   = 16
) (
    input  logic           clk,
    input  logic           reset,
    gpu_mem_controller_if.slave bus
);

    localparam int IW = idx_w(NUM_CORES);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

    logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CORES-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CORES-1:0][DATA_WIDTH-1:0] rdata_q;

    mc_state_e            state, state_n;
    logic [IW-1:0]        rr_ptr, grant_idx, g_q;
    logic [NUM_CORES-1:0] grant_onehot, ready_c, resp_c;
    logic                 grant_any;
    logic                 we_q, en_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < MEM_LIMIT;
    endfunction

    assign req_addr  = bus.core_req_addr;
    assign req_wdata = bus.core_req_wdata;

    gpu_mem_controller_rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_arb (
        .req          (bus.core_req_valid),
        .ptr          (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= MC_IDLE;
        else       state <= state_n;
    end

    // Fixed four-step walk per request; accept and response pulses decoded from state.
    always_comb begin
        state_n = state;
        ready_c = '0;
        resp_c  = '0;
        case (state)
            MC_IDLE: begin
                ready_c = grant_onehot;
                if (grant_any) state_n = MC_ISSUE;
            end
            MC_ISSUE:   state_n = MC_WAIT;
            MC_WAIT:    state_n = MC_RESPOND;
            MC_RESPOND: begin
                resp_c[g_q] = 1'b1;
                state_n     = MC_IDLE;
            end
            default:    state_n = MC_IDLE;
        endcase
    end

    // Request latch, memory strobes, per-core read data and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q      <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            en_q     <= 1'b0;
            mem_we_q <= 1'b0;
            rr_ptr   <= '0;
            rdata_q  <= '0;
        end else begin
            en_q     <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (grant_any) begin
                        g_q      <= grant_idx;
                        we_q     <= bus.core_req_we[grant_idx];
                        addr_q   <= req_addr[grant_idx];
                        wdata_q  <= req_wdata[grant_idx];
                        en_q     <= 1'b1;
                        // Out-of-range stores still occupy the slot but never touch memory.
                        mem_we_q <= bus.core_req_we[grant_idx] && in_range(req_addr[grant_idx]);
                    end
                end
                MC_WAIT: begin
                    if (!we_q) rdata_q[g_q] <= in_range(addr_q) ? bus.mem_rdata : '0;
                end
                MC_RESPOND: begin
                    rr_ptr <= (g_q == IW'(NUM_CORES-1)) ? '0 : g_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset masks the strobes and pulses at once, so a store caught mid-issue is dropped.
    assign bus.core_req_ready  = reset ? '0 : ready_c;
    assign bus.core_resp_valid = reset ? '0 : resp_c;
    assign bus.core_resp_rdata = rdata_q;
    assign bus.mem_en          = en_q & ~reset;
    assign bus.mem_we          = mem_we_q & ~reset;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wdata       = wdata_q;

endmodule

// File: tb/tb_gpu_mem_controller.sv
// Bench for gpu_mem_controller: directed vectors, corner sequences and random traffic.
// Latency: expects ready at T, mem_en at T+1, resp at T+3.
// Backpressure: cores hold requests until ready, then wait for their response.
module tb_gpu_mem_controller;

    localparam int NC = 2;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MS = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpu_mem_controller_if #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    gpu_mem_controller #(.NUM_CORES(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NC-1:0]         d_valid, d_we;
    logic [NC-1:0][AW-1:0] d_addr;
    logic [NC-1:0][DW-1:0] d_wdata;
    assign bus.core_req_valid = d_valid;
    assign bus.core_req_we    = d_we;
    assign bus.core_req_addr  = d_addr;
    assign bus.core_req_wdata = d_wdata;

    // 16x8 sync-read data memory behind the controller.
    logic [DW-1:0] mem [16] = '{0: 8'd5, 1: 8'd3, 2: 8'd7, 3: 8'd2, default: 8'd0};
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int ready_cnt [NC];
    int resp_cnt  [NC];
    int grant_log [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a request seen while the controller is free is granted
    // by round robin, strobes memory one cycle later and answers three cycles later.
    task automatic monitor();
        int mcyc = 0, free_at = 0, issue_at = -1, resp_at = -1, rr = 0;
        int pg = 0, pwe = 0, paddr = 0, pwdata = 0;
        bit prev_rst = 1'b1;
        logic [NC-1:0] er;
        logic [DW-1:0] ref_mem [16];
        logic [DW-1:0] ref_rd  [NC];
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_mem[0] = 8'd5; ref_mem[1] = 8'd3; ref_mem[2] = 8'd7; ref_mem[3] = 8'd2;
        for (int i = 0; i < NC; i++) ref_rd[i] = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            for (int i = 0; i < NC; i++) begin
                if (bus.core_req_ready[i]) begin
                    ready_cnt[i]++;
                    grant_log.push_back(i);
                end
                if (bus.core_resp_valid[i]) resp_cnt[i]++;
            end
            if (reset) begin
                if (prev_rst)
                    check("reset_outputs", {bus.core_req_ready, bus.core_resp_valid, bus.core_resp_rdata,
                                            bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
                free_at = mcyc + 1; issue_at = -1; resp_at = -1; rr = 0;
                for (int i = 0; i < NC; i++) ref_rd[i] = '0;
            end else begin
                er = '0;
                if (mcyc >= free_at && bus.core_req_valid != '0) begin
                    for (int k = 0; k < NC; k++)
                        if (er == '0 && bus.core_req_valid[(rr + k) % NC]) begin
                            pg = (rr + k) % NC;
                            er[pg] = 1'b1;
                        end
                    pwe    = int'(bus.core_req_we[pg]);
                    paddr  = int'(bus.core_req_addr[pg*AW +: AW]);
                    pwdata = int'(bus.core_req_wdata[pg*DW +: DW]);
                    issue_at = mcyc + 1; resp_at = mcyc + 3; free_at = mcyc + 4;
                    rr = (pg + 1) % NC;
                end
                check("ready", bus.core_req_ready, er);
                if (mcyc == issue_at) begin
                    check("mem_en", bus.mem_en, 1);
                    check("mem_we", bus.mem_we, (pwe != 0 && paddr < MS) ? 1 : 0);
                    check("mem_addr", bus.mem_addr, paddr);
                    if (pwe != 0) check("mem_wdata", bus.mem_wdata, pwdata);
                    if (pwe != 0 && paddr < MS) ref_mem[paddr] = DW'(pwdata);
                end else begin
                    check("mem_idle", {bus.mem_en, bus.mem_we}, 0);
                end
                if (mcyc == resp_at) begin
                    if (pwe == 0) ref_rd[pg] = (paddr < MS) ? ref_mem[paddr] : '0;
                    check("resp_valid", bus.core_resp_valid, 1 << pg);
                    for (int i = 0; i < NC; i++)
                        check("resp_rdata", bus.core_resp_rdata[i*DW +: DW], ref_rd[i]);
                end else begin
                    check("resp_idle", bus.core_resp_valid, 0);
                end
            end
            prev_rst = reset;
        end
    endtask

    typedef struct {
        int core;
        bit we;
        int addr;
        int wdata;
        bit exp_we;
        int exp_rdata;
    } vec_t;

    function automatic vec_t mk(int c, bit w, int a, int d, bit ew, int er);
        vec_t v;
        v.core = c; v.we = w; v.addr = a; v.wdata = d; v.exp_we = ew; v.exp_rdata = er;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; d_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One isolated request with exact latency checks against the vector's expectations.
    task automatic do_txn(input vec_t v);
        bit got = 1'b0;
        int lat = -1;
        @(posedge clk); #1;
        d_valid[v.core] = 1'b1;
        d_we[v.core]    = v.we;
        d_addr[v.core]  = AW'(v.addr);
        d_wdata[v.core] = DW'(v.wdata);
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.core_req_ready[v.core]) begin got = 1'b1; lat = k; end
        end
        if (!got) begin
            check("txn_ready_timeout", 0, 1);
            d_valid[v.core] = 1'b0;
            return;
        end
        check("txn_ready_lat", lat, 0);
        @(posedge clk); #1 d_valid[v.core] = 1'b0;
        @(negedge clk);
        check("txn_mem_en", bus.mem_en, 1);
        check("txn_mem_we", bus.mem_we, v.exp_we);
        @(negedge clk);
        @(negedge clk);
        check("txn_resp_valid", bus.core_resp_valid, 1 << v.core);
        check("txn_rdata", bus.core_resp_rdata[v.core*DW +: DW], v.exp_rdata);
    endtask

    // Both cores load in the same cycle; core0 must win, core1 follows four cycles later.
    task automatic contention(input int a0, input int a1, input int e0, input int e1);
        int r0 = -1, r1 = -1, s0 = -1, s1 = -1, v0 = -1, v1 = -1;
        @(posedge clk); #1;
        d_valid = '1; d_we = '0;
        d_addr[0] = AW'(a0); d_addr[1] = AW'(a1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.core_req_ready[0] && r0 < 0) r0 = k;
            if (bus.core_req_ready[1] && r1 < 0) r1 = k;
            if (bus.core_resp_valid[0]) begin s0 = k; v0 = int'(bus.core_resp_rdata[0 +: DW]); end
            if (bus.core_resp_valid[1]) begin s1 = k; v1 = int'(bus.core_resp_rdata[DW +: DW]); end
            @(posedge clk); #1;
            if (r0 >= 0) d_valid[0] = 1'b0;
            if (r1 >= 0) d_valid[1] = 1'b0;
        end
        d_valid = '0;
        check("cont_grant0_cyc", r0, 0);
        check("cont_grant1_cyc", r1, 4);
        check("cont_resp0_cyc", s0, 3);
        check("cont_resp1_cyc", s1, 7);
        check("cont_rdata0", v0, e0);
        check("cont_rdata1", v1, e1);
    endtask

    // Protocol-respecting cores: request with req_pct, withdraw unaccepted requests with drop_pct.
    task automatic traffic(input int ncyc, input int req_pct, input int drop_pct);
        bit pend [NC];
        bit busy [NC];
        int sr [NC];
        int ss [NC];
        int c = 0;
        bit done = 1'b0;
        for (int i = 0; i < NC; i++) begin
            pend[i] = 1'b0; busy[i] = 1'b0; sr[i] = ready_cnt[i]; ss[i] = resp_cnt[i];
        end
        while (!done && c < ncyc + 40) begin
            @(posedge clk); #1;
            for (int i = 0; i < NC; i++) begin
                if (ready_cnt[i] != sr[i]) begin
                    sr[i] = ready_cnt[i]; pend[i] = 1'b0; busy[i] = 1'b1; d_valid[i] = 1'b0;
                end
                if (resp_cnt[i] != ss[i]) begin
                    ss[i] = resp_cnt[i]; busy[i] = 1'b0;
                end
                if (pend[i] && (c >= ncyc || $urandom_range(99) < drop_pct)) begin
                    pend[i] = 1'b0; d_valid[i] = 1'b0;
                end else if (!pend[i] && !busy[i] && c < ncyc && $urandom_range(99) < req_pct) begin
                    pend[i]    = 1'b1;
                    d_valid[i] = 1'b1;
                    d_we[i]    = 1'($urandom_range(1));
                    d_addr[i]  = AW'($urandom_range(15));
                    d_wdata[i] = DW'($urandom);
                end
            end
            c++;
            if (c > ncyc) begin
                done = 1'b1;
                for (int i = 0; i < NC; i++) if (pend[i] || busy[i]) done = 1'b0;
            end
        end
        check("traffic_drain", done, 1);
    endtask

    vec_t vecs [12];

    initial begin
        int rsum, nres;
        vecs[0]  = mk(0, 0,  0, 8'h00, 0, 8'd5);
        vecs[1]  = mk(1, 0,  1, 8'h00, 0, 8'd3);
        vecs[2]  = mk(0, 0,  2, 8'h00, 0, 8'd7);
        vecs[3]  = mk(1, 0,  3, 8'h00, 0, 8'd2);
        vecs[4]  = mk(1, 1,  9, 8'h09, 1, 8'd2);
        vecs[5]  = mk(1, 0,  9, 8'h00, 0, 8'd9);
        vecs[6]  = mk(0, 1, 13, 8'hAA, 0, 8'd7);
        vecs[7]  = mk(0, 0, 13, 8'h00, 0, 8'd0);
        vecs[8]  = mk(0, 1, 11, 8'h33, 1, 8'd0);
        vecs[9]  = mk(0, 0, 11, 8'h00, 0, 8'h33);
        vecs[10] = mk(1, 0, 12, 8'h00, 0, 8'd0);
        vecs[11] = mk(1, 1, 15, 8'h44, 0, 8'd0);

        reset = 1'b1;
        d_valid = '0; d_we = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < NC; i++) begin ready_cnt[i] = 0; resp_cnt[i] = 0; end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) do_txn(vecs[i]);
        check("mem9_written", mem[9], 8'd9);
        check("mem13_untouched", mem[13], 8'd0);
        check("mem15_untouched", mem[15], 8'd0);

        do_reset();
        contention(2, 3, 7, 2);
        contention(0, 1, 5, 3);

        // Reset lands on the ISSUE cycle of a core0 store.
        do_reset();
        @(posedge clk); #1;
        d_valid[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 4'd4; d_wdata[0] = 8'h55;
        @(negedge clk);
        check("rst_grant", bus.core_req_ready, 2'b01);
        @(posedge clk); #1;
        d_valid[0] = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("rst_issue_mem", {bus.mem_en, bus.mem_we}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_all_zero", {bus.core_req_ready, bus.core_resp_valid, bus.core_resp_rdata,
                               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        @(posedge clk); #1 reset = 1'b0;
        nres = resp_cnt[0] + resp_cnt[1];
        repeat (6) @(negedge clk);
        check("rst_no_resp", resp_cnt[0] + resp_cnt[1] - nres, 0);
        check("rst_mem4_kept", mem[4], 8'd0);
        do_txn(mk(0, 0, 4, 0, 0, 0));

        // Fairness: both cores keep requesting for 16 cycles.
        do_reset();
        grant_log.delete();
        rsum = resp_cnt[0] + resp_cnt[1];
        traffic(16, 100, 0);
        check("fair_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
        check("fair_resps", resp_cnt[0] + resp_cnt[1] - rsum, 4);

        traffic(800, 35, 15);
        do_reset();
        traffic(400, 80, 5);
        grant_log.delete();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
